arcade_input_conditioner: RTL and testbench

- Parametrised input front-end between board GPIO/push-buttons and the arcade core's active-low control buses (ip_1p, ip_2p, ip_coin*).
- Per channel: two-flop synchronisation, polarity correction, tick-based debounce, and a per-channel output mode (level, fixed-width one-shot for coin mechanisms, autofire).
- Replaces the ad-hoc inversion and raw key wiring in board tops. One instance serves all controls of a board.

---
 rtl/arcade_io_pkg.sv | 24 ++
 rtl/input_channel.sv | 113 +++++++++++
 rtl/arcade_input_conditioner.sv | 71 +++++++
 tb/tb_arcade_input_conditioner.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/arcade_io_pkg.sv
// Shared definitions for the arcade input conditioner: output modes, counter
// widths and debounce tick dividers for the common board clocks.
package arcade_io_pkg;

    typedef enum logic [1:0] {
        MODE_LEVEL = 2'd0,
        MODE_PULSE = 2'd1,
        MODE_AF    = 2'd2
    } mode_e;

    localparam int DEB_W   = 8;
    localparam int PULSE_W = 16;

    localparam int TICK_DIV_24M576 = 24576;
    localparam int TICK_DIV_24M000 = 24000;

    // One-shot outranks autofire, which outranks plain level.
    function automatic mode_e sel_mode(input logic pulse_sel, input logic af_sel);
        if (pulse_sel)   return MODE_PULSE;
        else if (af_sel) return MODE_AF;
        else             return MODE_LEVEL;
    endfunction

endpackage

// File: rtl/input_channel.sv
// One conditioned input: tick-based debounce followed by level, one-shot or
// autofire output shaping.
module input_channel
    import arcade_io_pkg::*;
#(
    parameter int DEB_TICKS     = 8,
    parameter int PULSE_TICKS   = 50,
    parameter int AF_HALF_TICKS = 33
) (
    input  logic clk,
    input  logic rst_i,
    input  logic tick_i,
    input  logic s_i,
    input  logic pulse_sel_i,
    input  logic af_sel_i,
    output logic btn_o,
    output logic rise_o
);

    localparam logic [DEB_W-1:0]   DEB_LIM = DEB_W'(DEB_TICKS);
    localparam logic [PULSE_W-1:0] PC_LD   = PULSE_W'(PULSE_TICKS);
    localparam logic [PULSE_W-1:0] AC_LD   = PULSE_W'(AF_HALF_TICKS);

    mode_e              mode;
    logic               stable_q, stable_d;
    logic [DEB_W-1:0]   deb_q, deb_d, deb_inc;
    logic [PULSE_W-1:0] pc_q, pc_d;
    logic [PULSE_W-1:0] ac_q, ac_d;
    logic               phase_q, phase_d;
    logic               rise_q, rise_d;
    logic               btn_q, btn_d;

    always_comb begin
        mode     = sel_mode(pulse_sel_i, af_sel_i);
        stable_d = stable_q;
        deb_d    = deb_q;
        deb_inc  = deb_q + DEB_W'(1);
        pc_d     = pc_q;
        ac_d     = ac_q;
        phase_d  = phase_q;

        if (s_i == stable_q) begin
            deb_d = '0;
        end else if (tick_i) begin
            if (deb_inc == DEB_LIM) begin
                stable_d = s_i;
                deb_d    = '0;
            end else begin
                deb_d = deb_inc;
            end
        end

        rise_d = stable_d & ~stable_q;

        // A press during a running pulse neither retriggers nor extends it.
        if (mode != MODE_PULSE) begin
            pc_d = '0;
        end else if (rise_d && (pc_q == '0)) begin
            pc_d = PC_LD;
        end else if (tick_i && (pc_q != '0)) begin
            pc_d = pc_q - PULSE_W'(1);
        end

        if (mode != MODE_AF) begin
            ac_d    = '0;
            phase_d = 1'b0;
        end else if (rise_d) begin
            ac_d    = AC_LD;
            phase_d = 1'b1;
        end else if (!stable_q) begin
            ac_d    = '0;
            phase_d = 1'b0;
        end else if (tick_i) begin
            // ac_q of 0 only happens when autofire is entered mid-hold.
            if (ac_q <= PULSE_W'(1)) begin
                ac_d    = AC_LD;
                phase_d = ~phase_q;
            end else begin
                ac_d = ac_q - PULSE_W'(1);
            end
        end

        case (mode)
            MODE_PULSE: btn_d = (pc_q != '0);
            MODE_AF:    btn_d = stable_q & phase_q;
            default:    btn_d = stable_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            stable_q <= 1'b0;
            deb_q    <= '0;
            pc_q     <= '0;
            ac_q     <= '0;
            phase_q  <= 1'b0;
            rise_q   <= 1'b0;
            btn_q    <= 1'b0;
        end else begin
            stable_q <= stable_d;
            deb_q    <= deb_d;
            pc_q     <= pc_d;
            ac_q     <= ac_d;
            phase_q  <= phase_d;
            rise_q   <= rise_d;
            btn_q    <= btn_d;
        end
    end

    assign btn_o  = btn_q;
    assign rise_o = rise_q;

endmodule

// File: rtl/arcade_input_conditioner.sv
// Board input front-end: tick prescaler, two-flop synchronisers, polarity
// correction and one conditioned channel per control input.
module arcade_input_conditioner
    import arcade_io_pkg::*;
#(
    parameter int NUM_CH        = 8,
    parameter int TICK_DIV      = 24576,
    parameter int DEB_TICKS     = 8,
    parameter int PULSE_TICKS   = 50,
    parameter int AF_HALF_TICKS = 33
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] raw_in,
    input  logic [NUM_CH-1:0] invert_mask,
    input  logic [NUM_CH-1:0] pulse_mask,
    input  logic [NUM_CH-1:0] af_mask,
    input  logic              af_en,
    output logic [NUM_CH-1:0] btn_out,
    output logic [NUM_CH-1:0] btn_out_n,
    output logic [NUM_CH-1:0] rise_out,
    output logic              tick_out
);

    localparam int            PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]     presc_q, presc_d;
    logic [NUM_CH-1:0] sync1_q, sync2_q;
    logic [NUM_CH-1:0] s;

    always_comb begin
        presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + PW'(1);
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            presc_q <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            presc_q <= presc_d;
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    assign tick_out = (presc_q == PRE_LAST);
    // Polarity is applied after the flops so reset state ignores invert_mask.
    assign s = sync2_q ^ invert_mask;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        input_channel #(
            .DEB_TICKS     (DEB_TICKS),
            .PULSE_TICKS   (PULSE_TICKS),
            .AF_HALF_TICKS (AF_HALF_TICKS)
        ) u_ch (
            .clk         (clk),
            .rst_i       (RESET),
            .tick_i      (tick_out),
            .s_i         (s[g]),
            .pulse_sel_i (pulse_mask[g]),
            .af_sel_i    (af_mask[g] & af_en),
            .btn_o       (btn_out[g]),
            .rise_o      (rise_out[g])
        );
    end

    assign btn_out_n = ~btn_out;

endmodule

// File: tb/tb_arcade_input_conditioner.sv
// Directed bench for arcade_input_conditioner with a short tick so debounce,
// one-shot and autofire timing can be checked cycle by cycle.
module tb_arcade_input_conditioner;

    logic       clk = 1'b0;
    logic       RESET;
    logic [3:0] raw_in, invert_mask, pulse_mask, af_mask;
    logic       af_en;
    logic [3:0] btn_out, btn_out_n, rise_out;
    logic       tick_out;

    int checks = 0;
    int errors = 0;

    int   rise_cnt[4] = '{default: 0};
    logic rise_wide   = 1'b0;
    logic [3:0] rise_prev = '0;
    int   run2 = 0, last_w2 = 0, np2 = 0;
    int   n;

    arcade_input_conditioner #(
        .NUM_CH        (4),
        .TICK_DIV      (4),
        .DEB_TICKS     (3),
        .PULSE_TICKS   (5),
        .AF_HALF_TICKS (2)
    ) dut (
        .clk         (clk),
        .RESET       (RESET),
        .raw_in      (raw_in),
        .invert_mask (invert_mask),
        .pulse_mask  (pulse_mask),
        .af_mask     (af_mask),
        .af_en       (af_en),
        .btn_out     (btn_out),
        .btn_out_n   (btn_out_n),
        .rise_out    (rise_out),
        .tick_out    (tick_out)
    );

    always #5 clk = ~clk;

    // Strobe counts, strobe width and channel-2 high-run lengths.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (rise_out[i]) rise_cnt[i]++;
        if ((rise_out & rise_prev) != 4'b0) rise_wide = 1'b1;
        rise_prev = rise_out;
        if (btn_out[2]) run2++;
        else if (run2 != 0) begin
            last_w2 = run2;
            np2++;
            run2 = 0;
        end
    end

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_btn(input int ch, input logic v, input int budget, output int cnt);
        cnt = 0;
        while (btn_out[ch] !== v && cnt < budget) begin
            step(1);
            cnt++;
        end
    endtask

    initial begin
        RESET = 1'b1; raw_in = 4'hF; invert_mask = 4'hF;
        pulse_mask = 4'h0; af_mask = 4'h0; af_en = 1'b0;
        step(3);
        check("rst_btn",   32'(btn_out),   32'h0);
        check("rst_btn_n", 32'(btn_out_n), 32'hF);
        check("rst_rise",  32'(rise_out),  32'h0);
        check("rst_tick",  32'(tick_out),  32'h0);
        RESET = 1'b0;
        step(30);
        check("post_rst_btn",   32'(btn_out),   32'h0);
        check("post_rst_btn_n", 32'(btn_out_n), 32'hF);
        check("post_rst_rises", 32'(rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3]), 0);

        // Prescaler: tick every 4 clk, 1 clk wide.
        n = 0;
        while (tick_out !== 1'b1 && n < 8) begin step(1); n++; end
        check("tick_seen", 32'(tick_out), 1);
        step(1);
        check("tick_low", 32'(tick_out), 0);
        step(3);
        check("tick_period", 32'(tick_out), 1);

        // Level press on active-low pin 0: 2 clk + 2..3 ticks + 1 clk.
        raw_in[0] = 1'b0;
        wait_btn(0, 1'b1, 30, n);
        check("lat0_press", 32'(n >= 11 && n <= 15), 1);
        check("btn_n0", 32'(btn_out_n[0]), 0);
        check("rise0_cnt", 32'(rise_cnt[0]), 1);
        raw_in[0] = 1'b1;
        wait_btn(0, 1'b0, 30, n);
        check("lat0_release", 32'(n >= 11 && n <= 15), 1);
        check("rise0_after_rel", 32'(rise_cnt[0]), 1);

        // Glitch of 2 ticks rejected, then exactly 3 ticks accepted.
        raw_in[1] = 1'b0;
        step(8);
        raw_in[1] = 1'b1;
        step(30);
        check("glitch_btn",  32'(btn_out[1]), 0);
        check("glitch_rise", 32'(rise_cnt[1]), 0);
        raw_in[1] = 1'b0;
        step(12);
        raw_in[1] = 1'b1;
        wait_btn(1, 1'b1, 6, n);
        check("hold3_btn", 32'(btn_out[1]), 1);
        step(30);
        check("hold3_rel",   32'(btn_out[1]), 0);
        check("hold3_rise",  32'(rise_cnt[1]), 1);
        check("rise_width",  32'(rise_wide), 0);

        // Coin one-shot: 20 clk pulse, bounce during pulse does not extend it.
        pulse_mask[2] = 1'b1;
        raw_in[2] = 1'b0;
        wait_btn(2, 1'b1, 30, n);
        check("coin_start", 32'(btn_out[2]), 1);
        check("coin_rise",  32'(rise_cnt[2]), 1);
        step(4);
        raw_in[2] = 1'b1;
        step(4);
        raw_in[2] = 1'b0;
        wait_btn(2, 1'b0, 40, n);
        step(2);
        check("coin_end",   32'(btn_out[2]), 0);
        check("coin_width", 32'(last_w2 >= 17 && last_w2 <= 23), 1);
        check("coin_count", 32'(np2), 1);
        step(40);
        check("coin_held_off", 32'(btn_out[2]), 0);
        check("coin_held_rise", 32'(rise_cnt[2]), 1);
        raw_in[2] = 1'b1;
        step(30);
        raw_in[2] = 1'b0;
        wait_btn(2, 1'b1, 30, n);
        check("coin2_start", 32'(btn_out[2]), 1);
        wait_btn(2, 1'b0, 40, n);
        step(2);
        check("coin2_width", 32'(last_w2 >= 17 && last_w2 <= 23), 1);
        check("coin2_count", 32'(np2), 2);
        check("coin2_rise",  32'(rise_cnt[2]), 2);

        // Autofire: 8 clk high, 8 clk low, starting high.
        af_mask[3] = 1'b1;
        af_en = 1'b1;
        raw_in[3] = 1'b0;
        wait_btn(3, 1'b1, 30, n);
        check("af_start", 32'(btn_out[3]), 1);
        check("af_btn_n", 32'(btn_out_n[3]), 0);
        step(7);
        check("af_hi_end", 32'(btn_out[3]), 1);
        step(1);
        check("af_lo_start", 32'(btn_out[3]), 0);
        step(7);
        check("af_lo_end", 32'(btn_out[3]), 0);
        step(1);
        check("af_hi2", 32'(btn_out[3]), 1);
        raw_in[3] = 1'b1;
        step(20);
        check("af_rel", 32'(btn_out[3]), 0);
        step(20);
        check("af_rel_hold", 32'(btn_out[3]), 0);
        af_en = 1'b0;
        raw_in[3] = 1'b0;
        wait_btn(3, 1'b1, 30, n);
        check("af_off_start", 32'(btn_out[3]), 1);
        step(40);
        check("af_off_level", 32'(btn_out[3]), 1);
        raw_in[3] = 1'b1;
        step(30);
        check("af_off_rel", 32'(btn_out[3]), 0);

        // Mode switch mid-pulse: level while cleared, no pulse on return.
        raw_in[2] = 1'b1;
        step(30);
        raw_in[2] = 1'b0;
        wait_btn(2, 1'b1, 30, n);
        step(8);
        pulse_mask[2] = 1'b0;
        step(2);
        check("msw_level", 32'(btn_out[2]), 1);
        step(30);
        check("msw_level_hold", 32'(btn_out[2]), 1);
        pulse_mask[2] = 1'b1;
        step(2);
        check("msw_back", 32'(btn_out[2]), 0);
        step(30);
        check("msw_back_hold", 32'(btn_out[2]), 0);
        check("msw_rise", 32'(rise_cnt[2]), 3);

        // Async reset mid-pulse and mid-autofire.
        raw_in[2] = 1'b1;
        step(30);
        af_en = 1'b1;
        raw_in[2] = 1'b0;
        raw_in[3] = 1'b0;
        wait_btn(2, 1'b1, 30, n);
        step(3);
        check("pre_rst_btn", 32'(btn_out), 32'hC);
        #3;
        RESET = 1'b1;
        raw_in = 4'hF;
        #1;
        check("async_rst_btn",   32'(btn_out),   32'h0);
        check("async_rst_btn_n", 32'(btn_out_n), 32'hF);
        step(3);
        RESET = 1'b0;
        step(10);
        check("rst_rel_btn", 32'(btn_out), 32'h0);
        step(50);
        check("rst_rel_btn_late", 32'(btn_out), 32'h0);
        check("rst_rise2", 32'(rise_cnt[2]), 4);
        check("rst_rise3", 32'(rise_cnt[3]), 3);
        check("rise_width_end", 32'(rise_wide), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
